// File: rtl/bomb_game_ctrl_pkg.sv
// Shared definitions for the bomb defusal game controller: game_state codes,
// BCD digit type and the difficulty-to-countdown preload table.
package bomb_pkg;

  typedef logic [3:0] bcd_t;

  typedef enum logic [7:0] {
    GS_IDLE     = 8'h00,
    GS_ARMED    = 8'h10,
    GS_DEFUSED  = 8'h20,
    GS_EXPLODED = 8'h30
  } game_state_e;

  // Packing is {ones, tens, hundreds}, matching what the Countdown counter loads.
  function automatic logic [11:0] init_time_for(input logic [1:0] difficulty);
    logic [11:0] t;
    case (difficulty)
      2'd0:    t = 12'h003;
      2'd1:    t = 12'h081;
      2'd2:    t = 12'h090;
      default: t = 12'h540;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/bomb_game_ctrl_if.sv
// Board-side signal bundle of the game controller; master is the controller,
// slave is the board (buttons, puzzle modules, countdown counter).
interface bomb_game_ctrl_if #(
  parameter int NUM_MODULES = 4
);
  import bomb_pkg::*;

  logic                   start;
  logic [1:0]             difficulty;
  logic [NUM_MODULES-1:0] module_done;
  logic                   strike;
  bcd_t                   value_three;
  bcd_t                   value_two;
  bcd_t                   value_one;
  logic [7:0]             game_state;
  logic [11:0]            init_time;
  logic [1:0]             strike_count;
  logic [11:0]            final_time;
  logic                   strike_flash;

  modport master (
    input  start, difficulty, module_done, strike, value_three, value_two, value_one,
    output game_state, init_time, strike_count, final_time, strike_flash
  );

  modport slave (
    output start, difficulty, module_done, strike, value_three, value_two, value_one,
    input  game_state, init_time, strike_count, final_time, strike_flash
  );

endinterface

// File: rtl/bomb_game_ctrl_strike_flash_timer.sv
// Loadable down-counter: strike_flash stays high for FLASH_CYCLES cycles after
// the most recent load; a new load restarts the full pulse.
module strike_flash_timer #(
  parameter int FLASH_CYCLES = 25000000
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic strike_flash
);
  localparam int CW = (FLASH_CYCLES < 1) ? 1 : $clog2(FLASH_CYCLES + 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      cnt_q <= '0;
    else if (load)
      cnt_q <= CW'(FLASH_CYCLES);
    else if (cnt_q != '0)
      cnt_q <= cnt_q - CW'(1);
  end

  assign strike_flash = (cnt_q != '0);

endmodule

// File: rtl/bomb_game_ctrl.sv
// Game sequencer: arms the countdown, tracks strikes and module completion,
// decides defuse vs. explosion and freezes the final time for the end screen.
//
// state       | meaning
// GS_IDLE     | waiting for start; init_time follows difficulty
// GS_ARMED    | countdown running; strikes and module_done watched
// GS_DEFUSED  | all modules solved; final_time frozen
// GS_EXPLODED | timeout or fatal strike; final_time frozen
module bomb_game_ctrl
  import bomb_pkg::*;
#(
  parameter int NUM_MODULES  = 4,
  parameter int MAX_STRIKES  = 3,
  parameter int ARM_GUARD    = 2,
  parameter int FLASH_CYCLES = 25000000
) (
  input logic             clk,
  input logic             reset,
  bomb_game_ctrl_if.master bus
);
  localparam int                     GW       = (ARM_GUARD < 1) ? 1 : $clog2(ARM_GUARD + 1);
  localparam logic [NUM_MODULES-1:0] ALL_DONE = '1;

  game_state_e   state_q, state_d;
  logic          start_q;
  logic [GW-1:0] guard_q, guard_d;
  logic [1:0]    count_q, count_d;
  logic [11:0]   final_q, final_d;
  logic [11:0]   init_q, init_d;
  logic          flash_load;

  logic start_edge, timeout, fatal, explode, defuse;

  assign start_edge = bus.start & ~start_q;
  assign timeout    = (guard_q == '0) &&
                      ({bus.value_three, bus.value_two, bus.value_one} == 12'h000);
  assign fatal      = bus.strike && (count_q == 2'(MAX_STRIKES - 1));
  assign explode    = timeout || fatal;
  assign defuse     = (bus.module_done == ALL_DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= GS_IDLE;
      start_q <= 1'b0;
      guard_q <= '0;
      count_q <= 2'd0;
      final_q <= 12'h000;
      init_q  <= 12'h003;
    end else begin
      state_q <= state_d;
      start_q <= bus.start;
      guard_q <= guard_d;
      count_q <= count_d;
      final_q <= final_d;
      init_q  <= init_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      GS_IDLE:  if (start_edge) state_d = GS_ARMED;
      GS_ARMED: begin
        if (explode)     state_d = GS_EXPLODED;
        else if (defuse) state_d = GS_DEFUSED;
      end
      default:  if (start_edge) state_d = GS_IDLE;
    endcase
  end

  always_comb begin
    guard_d    = guard_q;
    count_d    = count_q;
    final_d    = final_q;
    init_d     = init_q;
    flash_load = 1'b0;
    unique case (state_q)
      GS_IDLE: begin
        init_d = init_time_for(bus.difficulty);
        if (start_edge) begin
          count_d = 2'd0;
          guard_d = GW'(ARM_GUARD);
        end
      end
      GS_ARMED: begin
        if (guard_q != '0) guard_d = guard_q - GW'(1);
        // The fatal strike still flashes but is not counted.
        flash_load = bus.strike;
        if (bus.strike && !fatal && (count_q < 2'(MAX_STRIKES)))
          count_d = count_q + 2'd1;
        if (explode || defuse)
          final_d = {bus.value_one, bus.value_two, bus.value_three};
      end
      default: ;
    endcase
  end

  strike_flash_timer #(
    .FLASH_CYCLES(FLASH_CYCLES)
  ) u_flash (
    .clk         (clk),
    .reset       (reset),
    .load        (flash_load),
    .strike_flash(bus.strike_flash)
  );

  assign bus.game_state   = state_q;
  assign bus.init_time    = init_q;
  assign bus.strike_count = count_q;
  assign bus.final_time   = final_q;

endmodule

// File: tb/tb_bomb_game_ctrl.sv
// Directed bench for bomb_game_ctrl with a short strike flash so pulse length
// can be observed end to end.
module tb_bomb_game_ctrl;
  localparam int FLASH = 20;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  bomb_game_ctrl_if #(.NUM_MODULES(4)) bus ();

  bomb_game_ctrl #(
    .NUM_MODULES (4),
    .MAX_STRIKES (3),
    .ARM_GUARD   (2),
    .FLASH_CYCLES(FLASH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_digits(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
    bus.value_three = h;
    bus.value_two   = t;
    bus.value_one   = o;
  endtask

  task automatic do_reset();
    reset           = 1'b0;
    bus.start       = 1'b0;
    bus.difficulty  = 2'd0;
    bus.module_done = 4'b0000;
    bus.strike      = 1'b0;
    step(2);
    reset = 1'b1;
    step(1);
  endtask

  task automatic arm(input logic [1:0] diff);
    bus.difficulty = diff;
    step(1);
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
  endtask

  task automatic pulse_strike();
    bus.strike = 1'b1;
    step(1);
    bus.strike = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.start = 1'b0; bus.difficulty = 2'd2; bus.module_done = 4'b0000; bus.strike = 1'b0;
    set_digits(4'd1, 4'd2, 4'd3);
    #23;
    checks++; if (bus.game_state !== 8'h00) begin errors++; $display("FAIL reset_gs: got %h want 00", bus.game_state); end
    checks++; if (bus.init_time !== 12'h003) begin errors++; $display("FAIL reset_init: got %h want 003", bus.init_time); end
    checks++; if (bus.strike_count !== 2'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", bus.strike_count); end
    checks++; if (bus.final_time !== 12'h000) begin errors++; $display("FAIL reset_final: got %h want 000", bus.final_time); end
    checks++; if (bus.strike_flash !== 1'b0) begin errors++; $display("FAIL reset_flash: got %b want 0", bus.strike_flash); end
    reset = 1'b1;
    step(1);
    checks++; if (bus.init_time !== 12'h090) begin errors++; $display("FAIL idle_init_d2: got %h want 090", bus.init_time); end
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    checks++; if (bus.game_state !== 8'h10) begin errors++; $display("FAIL arm_gs: got %h want 10", bus.game_state); end
    checks++; if (bus.init_time !== 12'h090) begin errors++; $display("FAIL arm_init: got %h want 090", bus.init_time); end
    checks++; if (bus.strike_count !== 2'd0) begin errors++; $display("FAIL arm_cnt: got %0d want 0", bus.strike_count); end
    bus.difficulty = 2'd3;
    step(2);
    checks++; if (bus.init_time !== 12'h090) begin errors++; $display("FAIL armed_init_hold: got %h want 090", bus.init_time); end
  endtask

  task automatic test_guard_timeout();
    do_reset();
    set_digits(4'd0, 4'd0, 4'd0);
    arm(2'd0);
    checks++; if (bus.init_time !== 12'h003) begin errors++; $display("FAIL guard_init_d0: got %h want 003", bus.init_time); end
    checks++; if (bus.game_state !== 8'h10) begin errors++; $display("FAIL guard_gs0: got %h want 10", bus.game_state); end
    step(1);
    checks++; if (bus.game_state !== 8'h10) begin errors++; $display("FAIL guard_gs1: got %h want 10", bus.game_state); end
    step(1);
    checks++; if (bus.game_state !== 8'h10) begin errors++; $display("FAIL guard_gs2: got %h want 10", bus.game_state); end
    set_digits(4'd0, 4'd4, 4'd5);
    step(3);
    checks++; if (bus.game_state !== 8'h10) begin errors++; $display("FAIL guard_running: got %h want 10", bus.game_state); end
    set_digits(4'd0, 4'd0, 4'd0);
    step(1);
    checks++; if (bus.game_state !== 8'h30) begin errors++; $display("FAIL timeout_gs: got %h want 30", bus.game_state); end
    checks++; if (bus.final_time !== 12'h000) begin errors++; $display("FAIL timeout_final: got %h want 000", bus.final_time); end
  endtask

  task automatic test_strikes();
    do_reset();
    set_digits(4'd1, 4'd2, 4'd3);
    arm(2'd1);
    checks++; if (bus.init_time !== 12'h081) begin errors++; $display("FAIL strk_init_d1: got %h want 081", bus.init_time); end
    step(2);
    pulse_strike();
    checks++; if (bus.strike_count !== 2'd1) begin errors++; $display("FAIL strk_cnt1: got %0d want 1", bus.strike_count); end
    checks++; if (bus.strike_flash !== 1'b1) begin errors++; $display("FAIL strk_flash1: got %b want 1", bus.strike_flash); end
    step(9);
    pulse_strike();
    checks++; if (bus.strike_count !== 2'd2) begin errors++; $display("FAIL strk_cnt2: got %0d want 2", bus.strike_count); end
    checks++; if (bus.game_state !== 8'h10) begin errors++; $display("FAIL strk_gs2: got %h want 10", bus.game_state); end
    step(9);
    pulse_strike();
    checks++; if (bus.game_state !== 8'h30) begin errors++; $display("FAIL strk_fatal_gs: got %h want 30", bus.game_state); end
    checks++; if (bus.strike_count !== 2'd2) begin errors++; $display("FAIL strk_fatal_cnt: got %0d want 2", bus.strike_count); end
    checks++; if (bus.strike_flash !== 1'b1) begin errors++; $display("FAIL strk_fatal_flash: got %b want 1", bus.strike_flash); end
    checks++; if (bus.final_time !== 12'h321) begin errors++; $display("FAIL strk_final: got %h want 321", bus.final_time); end
    step(2);
    pulse_strike();
    checks++; if (bus.game_state !== 8'h30) begin errors++; $display("FAIL strk4_gs: got %h want 30", bus.game_state); end
    checks++; if (bus.strike_count !== 2'd2) begin errors++; $display("FAIL strk4_cnt: got %0d want 2", bus.strike_count); end
    step(FLASH - 4);
    checks++; if (bus.strike_flash !== 1'b1) begin errors++; $display("FAIL flash_tail: got %b want 1", bus.strike_flash); end
    step(1);
    checks++; if (bus.strike_flash !== 1'b0) begin errors++; $display("FAIL flash_end: got %b want 0", bus.strike_flash); end
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    checks++; if (bus.game_state !== 8'h00) begin errors++; $display("FAIL exp_to_idle: got %h want 00", bus.game_state); end
    checks++; if (bus.strike_count !== 2'd2) begin errors++; $display("FAIL idle_cnt_kept: got %0d want 2", bus.strike_count); end
    step(1);
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    checks++; if (bus.game_state !== 8'h10) begin errors++; $display("FAIL rearm_gs: got %h want 10", bus.game_state); end
    checks++; if (bus.strike_count !== 2'd0) begin errors++; $display("FAIL rearm_cnt: got %0d want 0", bus.strike_count); end
  endtask

  task automatic test_defuse();
    do_reset();
    set_digits(4'd1, 4'd2, 4'd3);
    arm(2'd3);
    checks++; if (bus.init_time !== 12'h540) begin errors++; $display("FAIL def_init_d3: got %h want 540", bus.init_time); end
    step(3);
    bus.module_done = 4'b0001; step(1);
    bus.module_done = 4'b0011; step(1);
    bus.module_done = 4'b0111; step(1);
    checks++; if (bus.game_state !== 8'h10) begin errors++; $display("FAIL def_partial: got %h want 10", bus.game_state); end
    bus.module_done = 4'b1111; step(1);
    checks++; if (bus.game_state !== 8'h20) begin errors++; $display("FAIL def_gs: got %h want 20", bus.game_state); end
    checks++; if (bus.final_time !== 12'h321) begin errors++; $display("FAIL def_final: got %h want 321", bus.final_time); end
    set_digits(4'd0, 4'd0, 4'd7);
    pulse_strike();
    step(1);
    checks++; if (bus.final_time !== 12'h321) begin errors++; $display("FAIL def_final_hold: got %h want 321", bus.final_time); end
    checks++; if (bus.strike_count !== 2'd0) begin errors++; $display("FAIL def_strike_cnt: got %0d want 0", bus.strike_count); end
    checks++; if (bus.strike_flash !== 1'b0) begin errors++; $display("FAIL def_strike_flash: got %b want 0", bus.strike_flash); end
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    checks++; if (bus.game_state !== 8'h00) begin errors++; $display("FAIL def_to_idle: got %h want 00", bus.game_state); end
    bus.module_done = 4'b0000;
  endtask

  task automatic test_priority();
    do_reset();
    set_digits(4'd2, 4'd0, 4'd0);
    arm(2'd0);
    step(3);
    pulse_strike();
    step(2);
    pulse_strike();
    step(2);
    bus.module_done = 4'b1111;
    bus.strike      = 1'b1;
    step(1);
    bus.strike = 1'b0;
    checks++; if (bus.game_state !== 8'h30) begin errors++; $display("FAIL prio_gs: got %h want 30", bus.game_state); end
    checks++; if (bus.final_time !== 12'h002) begin errors++; $display("FAIL prio_final: got %h want 002", bus.final_time); end
    bus.module_done = 4'b0000;
  endtask

  task automatic test_reset_mid_game();
    do_reset();
    set_digits(4'd1, 4'd0, 4'd0);
    arm(2'd1);
    step(3);
    pulse_strike();
    step(1);
    pulse_strike();
    checks++; if (bus.strike_count !== 2'd2) begin errors++; $display("FAIL mid_cnt_pre: got %0d want 2", bus.strike_count); end
    #2;
    reset = 1'b0;
    bus.start = 1'b1;
    #1;
    checks++; if (bus.game_state !== 8'h00) begin errors++; $display("FAIL mid_async_gs: got %h want 00", bus.game_state); end
    checks++; if (bus.strike_count !== 2'd0) begin errors++; $display("FAIL mid_async_cnt: got %0d want 0", bus.strike_count); end
    checks++; if (bus.strike_flash !== 1'b0) begin errors++; $display("FAIL mid_async_flash: got %b want 0", bus.strike_flash); end
    checks++; if (bus.init_time !== 12'h003) begin errors++; $display("FAIL mid_async_init: got %h want 003", bus.init_time); end
    step(2);
    bus.start = 1'b0;
    step(1);
    reset = 1'b1;
    step(3);
    checks++; if (bus.game_state !== 8'h00) begin errors++; $display("FAIL mid_post_idle: got %h want 00", bus.game_state); end
    bus.start = 1'b1;
    step(1);
    checks++; if (bus.game_state !== 8'h10) begin errors++; $display("FAIL mid_fresh_arm: got %h want 10", bus.game_state); end
    step(3);
    checks++; if (bus.game_state !== 8'h10) begin errors++; $display("FAIL mid_start_held: got %h want 10", bus.game_state); end
    bus.start = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0; bus.difficulty = 2'd0; bus.module_done = 4'b0000; bus.strike = 1'b0;
    set_digits(4'd0, 4'd0, 4'd0);
    test_reset();
    test_guard_timeout();
    test_strikes();
    test_defuse();
    test_priority();
    test_reset_mid_game();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
